// File: rtl/ibus_cksyn_pkg.sv
// Shared types and default parameters for the ibus clk_ext synchroniser/detector.
package ibus_cksyn_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        FIRST    = 2'd1,
        ACQUIRE  = 2'd2,
        LOCKED   = 2'd3
    } cksyn_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_TOL         = 1;

endpackage

// File: rtl/ibus_cksyn_det_if.sv
// Toggle input and strobe/lock status outputs of the clk_ext detector.
interface ibus_cksyn_det_if
    import ibus_cksyn_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             toggle;
    logic             ext_strobe;
    logic             ext_pred;
    logic [CNT_W-1:0] ratio;
    logic             locked;
    logic             stalled;

    modport master (output toggle, input ext_strobe, ext_pred, ratio, locked, stalled);
    modport slave  (input toggle, output ext_strobe, ext_pred, ratio, locked, stalled);
endinterface

// File: rtl/ibus_cksyn_sync.sv
// Multi-flop synchroniser; the only place the asynchronous toggle is sampled.
module ibus_cksyn_sync
    import ibus_cksyn_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/ibus_cksyn_det.sv
// Detects clk_ext edges from the synchronised toggle, measures the clk:clk_ext
// ratio, locks once it is stable and then predicts each strobe one cycle early.
module ibus_cksyn_det
    import ibus_cksyn_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int TOL         = DEF_TOL
) (
    input logic             clk,
    input logic             rst_n,
    ibus_cksyn_det_if.slave bus
);
    localparam int                 MATCH_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W:0]     TOL_W      = (CNT_W + 1)'(TOL);
    localparam logic [MATCH_W-1:0] MATCH_DONE = MATCH_W'(LOCK_CNT);

    cksyn_state_t       state, state_next;
    logic               sync_last, sync_last_d, edge_seen, stall_hit;
    logic [CNT_W-1:0]   cnt, cand, cand_next, ratio_q, ratio_next, period_sat;
    logic [CNT_W:0]     period, diff_cand, diff_ratio;
    logic [MATCH_W-1:0] match, match_next, match_inc;
    logic               strobe_q, pred_q, locked_q, stalled_q;

    ibus_cksyn_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.toggle),
        .q     (sync_last)
    );

    // Differences are taken one bit wider than the counter so they never wrap.
    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a, input logic [CNT_W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign edge_seen  = sync_last ^ sync_last_d;
    assign stall_hit  = (cnt == CNT_MAX) && !edge_seen;
    assign period     = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign period_sat = period[CNT_W] ? CNT_MAX : period[CNT_W-1:0];
    assign diff_cand  = abs_diff(period, {1'b0, cand});
    assign diff_ratio = abs_diff(period, {1'b0, ratio_q});
    assign match_inc  = match + MATCH_W'(1);

    always_comb begin
        state_next = state;
        cand_next  = cand;
        match_next = match;
        ratio_next = ratio_q;
        if (stall_hit) begin
            state_next = UNLOCKED;
        end else if (edge_seen) begin
            case (state)
                UNLOCKED: state_next = FIRST;
                FIRST: begin
                    cand_next  = period_sat;
                    match_next = '0;
                    state_next = ACQUIRE;
                end
                ACQUIRE: begin
                    if (diff_cand <= TOL_W) begin
                        match_next = match_inc;
                        if (match_inc == MATCH_DONE) begin
                            state_next = LOCKED;
                            ratio_next = cand;
                        end
                    end else begin
                        cand_next  = period_sat;
                        match_next = '0;
                    end
                end
                LOCKED: begin
                    if (diff_ratio > TOL_W) begin
                        cand_next  = period_sat;
                        match_next = '0;
                        state_next = ACQUIRE;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= UNLOCKED;
            sync_last_d <= 1'b0;
            cnt         <= '0;
            cand        <= '0;
            match       <= '0;
            ratio_q     <= '0;
            strobe_q    <= 1'b0;
            pred_q      <= 1'b0;
            locked_q    <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state       <= state_next;
            sync_last_d <= sync_last;
            cand        <= cand_next;
            match       <= match_next;
            ratio_q     <= ratio_next;
            strobe_q    <= edge_seen;
            locked_q    <= (state_next == LOCKED);
            if (edge_seen)            cnt <= '0;
            else if (cnt != CNT_MAX)  cnt <= cnt + CNT_W'(1);
            if (edge_seen)            stalled_q <= 1'b0;
            else if (stall_hit)       stalled_q <= 1'b1;
            // Fires when the counter is one short of the edge-cycle value ratio-1.
            pred_q <= locked_q && (ratio_q >= CNT_W'(3)) && !edge_seen
                      && (cnt == ratio_q - CNT_W'(2));
        end
    end

    assign bus.ext_strobe = strobe_q;
    assign bus.ext_pred   = pred_q;
    assign bus.ratio      = ratio_q;
    assign bus.locked     = locked_q;
    assign bus.stalled    = stalled_q;
endmodule

// File: tb/tb_ibus_cksyn_det.sv
// Self-checking bench for ibus_cksyn_det: an event-level timing model checks
// every cycle of two instances (2- and 3-stage synchronisers), plus fixed vectors.
module tb_ibus_cksyn_det;
    localparam int M_UNLOCKED = 0;
    localparam int M_FIRST    = 1;
    localparam int M_ACQUIRE  = 2;
    localparam int M_LOCKED   = 3;
    localparam int LOCK_N     = 4;
    localparam int TOL_N      = 1;

    typedef struct {
        int gap;
        bit exp_locked;
        int exp_ratio;
    } vec_t;

    logic clk;
    logic rst_n;
    logic toggle;

    ibus_cksyn_det_if #(.CNT_W(8)) bus2 ();
    ibus_cksyn_det_if #(.CNT_W(8)) bus3 ();

    assign bus2.toggle = toggle;
    assign bus3.toggle = toggle;

    ibus_cksyn_det #(.SYNC_STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    ibus_cksyn_det #(.SYNC_STAGES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertions = 0;
    int failures   = 0;
    int n = 0;
    int since_change = 0;
    int pred_seen = 0;
    int strobe_seen = 0;
    int pred_then_strobe = 0;
    int last_strobe_n = 0;
    bit prev_pred = 0;

    // Reference model state: edges are timestamps, periods are timestamp gaps.
    int         pend0[$];
    int         pend1[$];
    int         m_last[2];
    int         m_mode[2];
    int         m_cand[2];
    int         m_match[2];
    logic [7:0] m_ratio[2];
    bit         m_locked[2], m_stalled[2], m_strobe[2], m_pred[2];

    function automatic int stages(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int dev(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic push_edge(input int d, input int at);
        if (d == 0) pend0.push_back(at);
        else        pend1.push_back(at);
    endtask

    task automatic model_step(input int d);
        int gap, cb, p;
        bit e;
        if (!rst_n) begin
            m_mode[d] = M_UNLOCKED; m_cand[d] = 0; m_match[d] = 0; m_ratio[d] = 8'd0;
            m_locked[d] = 0; m_stalled[d] = 0; m_strobe[d] = 0; m_pred[d] = 0;
            m_last[d] = n;
            if (d == 0) pend0.delete(); else pend1.delete();
            if (toggle) push_edge(d, n + stages(d) + 1);
            return;
        end
        e = 0;
        if (d == 0) begin
            if (pend0.size() > 0 && pend0[0] == n) begin e = 1; void'(pend0.pop_front()); end
        end else begin
            if (pend1.size() > 0 && pend1[0] == n) begin e = 1; void'(pend1.pop_front()); end
        end
        gap = n - m_last[d];
        cb  = (gap - 1 > 255) ? 255 : gap - 1;
        m_pred[d]   = m_locked[d] && (m_ratio[d] >= 3) && !e && (cb == int'(m_ratio[d]) - 2);
        m_strobe[d] = e;
        if (e) begin
            m_stalled[d] = 0;
            m_last[d] = n;
            p = (gap > 255) ? 255 : gap;
            case (m_mode[d])
                M_UNLOCKED: m_mode[d] = M_FIRST;
                M_FIRST: begin m_cand[d] = p; m_match[d] = 0; m_mode[d] = M_ACQUIRE; end
                M_ACQUIRE: begin
                    if (dev(gap, m_cand[d]) <= TOL_N) begin
                        m_match[d]++;
                        if (m_match[d] == LOCK_N) begin
                            m_mode[d] = M_LOCKED;
                            m_ratio[d] = 8'(m_cand[d]);
                        end
                    end else begin
                        m_cand[d] = p; m_match[d] = 0;
                    end
                end
                default: begin
                    if (dev(gap, int'(m_ratio[d])) > TOL_N) begin
                        m_cand[d] = p; m_match[d] = 0; m_mode[d] = M_ACQUIRE;
                    end
                end
            endcase
        end else if (cb == 255) begin
            m_stalled[d] = 1;
            m_mode[d] = M_UNLOCKED;
        end
        m_locked[d] = (m_mode[d] == M_LOCKED);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        logic [11:0] got, exp;
        @(posedge clk);
        #1;
        n++;
        since_change++;
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            got = (d == 0) ? {bus2.ext_strobe, bus2.ext_pred, bus2.locked, bus2.stalled, bus2.ratio}
                           : {bus3.ext_strobe, bus3.ext_pred, bus3.locked, bus3.stalled, bus3.ratio};
            exp = {m_strobe[d], m_pred[d], m_locked[d], m_stalled[d], m_ratio[d]};
            checkOutput($sformatf("cycle%0d_dut%0d", n, d), 32'(got), 32'(exp));
        end
        if (bus2.ext_pred) pred_seen++;
        if (bus2.ext_strobe) begin
            strobe_seen++;
            last_strobe_n = n;
            if (prev_pred) pred_then_strobe++;
        end
        prev_pred = bus2.ext_pred;
    endtask

    task automatic set_toggle(input logic v);
        toggle = v;
        push_edge(0, n + stages(0) + 1);
        push_edge(1, n + stages(1) + 1);
        since_change = 0;
    endtask

    // Waits until gap cycles have passed since the previous change, then flips toggle.
    task automatic applyStimulus(input int gap);
        while (since_change < gap) tick();
        set_toggle(!toggle);
    endtask

    task automatic do_reset(input logic level);
        if (toggle !== level) set_toggle(level);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        since_change = 0;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{8, 0, 0};  vecs[1]  = '{8, 0, 0};  vecs[2]  = '{8, 0, 0};
        vecs[3]  = '{8, 0, 0};  vecs[4]  = '{8, 0, 0};  vecs[5]  = '{8, 1, 8};
        vecs[6]  = '{9, 1, 8};  vecs[7]  = '{7, 1, 8};  vecs[8]  = '{8, 1, 8};
        vecs[9]  = '{11, 0, 8}; vecs[10] = '{11, 0, 8}; vecs[11] = '{11, 0, 8};
        vecs[12] = '{11, 0, 8}; vecs[13] = '{11, 1, 11};
        vecs[14] = '{8, 0, 11}; vecs[15] = '{8, 0, 11}; vecs[16] = '{8, 0, 11};
        vecs[17] = '{8, 0, 11}; vecs[18] = '{8, 1, 8};

        toggle = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        since_change = 0;
        checkOutput("reset_outputs", 32'({bus2.ext_strobe, bus2.ext_pred, bus2.locked, bus2.stalled, bus2.ratio}), 32'(0));

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].gap);
            repeat (3) tick();
            checkOutput($sformatf("vec%0d_strobe", i), 32'(bus2.ext_strobe), 32'(1));
            checkOutput($sformatf("vec%0d_locked", i), 32'(bus2.locked), 32'(vecs[i].exp_locked));
            checkOutput($sformatf("vec%0d_ratio", i), 32'(bus2.ratio), 32'(vecs[i].exp_ratio));
        end

        // Freeze toggle while locked at 8.
        begin
            int waited = 0;
            while (!bus2.stalled && waited < 400) begin
                tick();
                waited++;
            end
        end
        checkOutput("stall_reached", 32'(bus2.stalled), 32'(1));
        checkOutput("stall_delay", 32'(n - last_strobe_n), 32'(256));
        checkOutput("stall_locked", 32'(bus2.locked), 32'(0));
        checkOutput("stall_ratio", 32'(bus2.ratio), 32'(8));
        applyStimulus(1);
        repeat (3) tick();
        checkOutput("stall_clear", 32'(bus2.stalled), 32'(0));
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8);
            repeat (3) tick();
            checkOutput($sformatf("post_stall_lock%0d", i), 32'(bus2.locked), 32'(i == 5));
        end

        pred_seen = 0; strobe_seen = 0; pred_then_strobe = 0;
        repeat (4) begin applyStimulus(8); repeat (3) tick(); end
        checkOutput("pred_count_8", 32'(pred_seen), 32'(4));
        checkOutput("pred_before_strobe_8", 32'(pred_then_strobe), 32'(4));

        do_reset(1'b0);
        pred_seen = 0;
        repeat (12) applyStimulus(2);
        repeat (4) tick();
        checkOutput("ratio2_locked", 32'(bus2.locked), 32'(1));
        checkOutput("ratio2_ratio", 32'(bus2.ratio), 32'(2));
        checkOutput("ratio2_no_pred", 32'(pred_seen), 32'(0));

        repeat (6) applyStimulus(8);
        repeat (3) tick();
        checkOutput("relock8_locked", 32'(bus2.locked), 32'(1));
        do_reset(1'b1);
        checkOutput("midrun_reset_outputs", 32'({bus2.ext_strobe, bus2.ext_pred, bus2.locked, bus2.stalled, bus2.ratio}), 32'(0));
        strobe_seen = 0;
        repeat (10) tick();
        checkOutput("release_hi_strobes", 32'(strobe_seen <= 1), 32'(1));
        checkOutput("release_hi_locked", 32'(bus2.locked), 32'(0));

        do_reset(1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(8);
            repeat (3) tick();
            if (i >= 5) checkOutput($sformatf("reset_relock%0d", i), 32'(bus2.locked), 32'(i == 6));
        end
        checkOutput("reset_relock_ratio", 32'(bus2.ratio), 32'(8));

        // Edge arrives in exactly the cycle the counter saturates.
        do_reset(1'b0);
        applyStimulus(253);
        repeat (3) tick();
        checkOutput("sat_edge_strobe", 32'(bus2.ext_strobe), 32'(1));
        checkOutput("sat_edge_stalled", 32'(bus2.stalled), 32'(0));

        repeat (8) applyStimulus(5);
        repeat (4) tick();
        checkOutput("s3_locked", 32'(bus3.locked), 32'(1));
        checkOutput("s3_ratio", 32'(bus3.ratio), 32'(5));
        checkOutput("s2_ratio5", 32'(bus2.ratio), 32'(5));

        begin
            int base = 8;
            for (int i = 0; i < 300; i++) begin
                int gap;
                if ($urandom_range(0, 19) == 0) base = int'($urandom_range(1, 20));
                gap = base + int'($urandom_range(0, 2)) - 1;
                if (gap < 1) gap = 1;
                if ($urandom_range(0, 149) == 0) gap = 300;
                if ($urandom_range(0, 59) == 0) do_reset(1'($urandom_range(0, 1)));
                applyStimulus(gap);
            end
        end
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
